mul_operand_sequencer: RTL and testbench
========================================

MUL_OPERAND_SEQUENCER -- requirements
Module: mul_operand_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 16'd1000, max WAIT cycles before abandoning a job.
REQ-002 Port: clk  input  1  single clock; all state changes on posedge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  upstream operand pair valid.
REQ-005 Port: in_ready  output  1  sequencer can accept a pair this cycle.
REQ-006 Port: in_a  input  16  multiplicand.
REQ-007 Port: in_b  input  16  multiplier (repeat count).
REQ-008 Port: mul_start  output  1  start pulse to repeated-addition multiplier.
REQ-009 Port: mul_bus  output  16  shared operand bus to multiplier data input.
REQ-010 Port: mul_done  input  1  multiplier result ready (level).
REQ-011 Port: mul_product  input  16  multiplier product.
REQ-012 Port: out_valid  output  1  result held for downstream.
REQ-013 Port: out_ready  input  1  downstream accepts result.
REQ-014 Port: out_product  output  16  result, low 16 bits of a*b.
REQ-015 Port: out_err  output  1  result produced by timeout.
REQ-016 Port: busy  output  1  state not IDLE or FIFO non-empty.

Function
REQ-017 Input FIFO SHALL be 2 entries of {a,b}; push when in_valid && in_ready.
REQ-018 in_ready SHALL equal (FIFO count < 2), independent of same-cycle pop.
REQ-019 Simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-020 States SHALL be IDLE, ZERO, LD_A, LD_B, WAIT; encoding free.
REQ-021 IDLE: FIFO non-empty and out_valid=0 -> ZERO if head a==0 or b==0, else LD_A.
REQ-022 ZERO (1 cycle): load out_product=0, out_err=0, out_valid=1, pop head, -> IDLE; multiplier not started.
REQ-023 LD_A (1 cycle): mul_start=1, mul_bus=head a, -> LD_B.
REQ-024 LD_B (1 cycle): mul_start=0, mul_bus=head b, -> WAIT; wait counter cleared.
REQ-025 WAIT: mul_bus=0; mul_done sampled only here; counter increments each cycle.
REQ-026 WAIT with mul_done=1: out_product=mul_product, out_err=0, out_valid=1, pop, -> IDLE, same edge.
REQ-027 WAIT with counter==TIMEOUT-1 and mul_done=0: out_product=0, out_err=1, out_valid=1, pop, -> IDLE.
REQ-028 mul_done=1 on the timeout cycle SHALL win (normal result, out_err=0).
REQ-029 mul_start SHALL be high exactly one cycle per non-zero job; mul_bus=0 outside LD_A/LD_B.
REQ-030 out_valid/out_product/out_err SHALL hold stable until out_ready=1, then out_valid clears next edge.
REQ-031 No new job SHALL leave IDLE while out_valid=1 (one result outstanding max).
REQ-032 Product width SHALL be 16 bits; overflow truncates, no flag.
REQ-033 Minimum latency non-zero job: push edge to out_valid = 3 cycles + WAIT cycles; zero job = 2 cycles.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, FIFO empty, counter 0, mul_start=0, mul_bus=0, out_valid=0, out_product=0, out_err=0, in_ready=1, busy=0.
REQ-035 Reset mid-job SHALL discard FIFO contents and in-flight job; no result emitted.
REQ-036 First job after rst_n rises SHALL behave as from power-up.

Verification
REQ-037 Push a=17,b=5, mul_done rises 6 cycles into WAIT with mul_product=85 -> one mul_start pulse, bus 17 then 5, out_product=85, out_err=0.
REQ-038 Push a=0,b=9 -> mul_start never asserted, out_product=0, out_valid 2 cycles after push.
REQ-039 TIMEOUT=8, mul_done held 0 -> out_err=1, out_product=0 after 8 WAIT cycles.
REQ-040 Push 3 pairs back-to-back with out_ready=0 -> in_ready low after 2 in FIFO; results emitted in order as out_ready pulses.
REQ-041 Assert rst_n=0 during WAIT -> outputs reset same cycle; later job 3*4 returns 12.
REQ-042 a=300,b=300, mul_product=16'h5F90 -> out_product=16'h5F90, no error flag.

Source files
------------

// File: rtl/mul_operand_sequencer_if.sv
// Handshake and operand bus bundle between the operand sequencer, its upstream source,
// the repeated-addition multiplier and the downstream result consumer.
interface mul_operand_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        mul_start;
    logic [15:0] mul_bus;
    logic        mul_done;
    logic [15:0] mul_product;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_err;
    logic        busy;

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        input  in_ready, mul_start, mul_bus, out_valid, out_product, out_err, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        output in_ready, mul_start, mul_bus, out_valid, out_product, out_err, busy
    );
endinterface

// File: rtl/mul_operand_sequencer.sv
// Feeds {a,b} pairs from a 2-deep FIFO to a shared-bus repeated-addition multiplier,
// short-circuits zero operands, and abandons jobs that exceed TIMEOUT wait cycles.
module mul_operand_sequencer #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mul_operand_sequencer_if.slave  sif
);
    localparam int DATA_W = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ZERO = 3'd1;
    localparam logic [2:0] S_LD_A = 3'd2;
    localparam logic [2:0] S_LD_B = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [DATA_W-1:0] r_fifo_a [2];
    logic [DATA_W-1:0] r_fifo_b [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [15:0]       r_wait_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_product;
    logic              r_out_err;

    logic              w_push;
    logic              w_pop;
    logic              w_done_ok;
    logic              w_timeout;
    logic [DATA_W-1:0] w_head_a;
    logic [DATA_W-1:0] w_head_b;
    logic [DATA_W-1:0] w_mul_bus;

    assign w_head_a  = r_fifo_a[r_rd_ptr];
    assign w_head_b  = r_fifo_b[r_rd_ptr];
    assign w_push    = sif.in_valid && sif.in_ready;
    assign w_done_ok = (r_state == S_WAIT) && sif.mul_done;
    // Done on the final wait cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_WAIT) && !sif.mul_done && (r_wait_cnt == TIMEOUT - 16'd1);
    assign w_pop     = (r_state == S_ZERO) || w_done_ok || w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != 2'd0 && !r_out_valid) begin
                    if (w_head_a == '0 || w_head_b == '0) w_state_nxt = S_ZERO;
                    else                                  w_state_nxt = S_LD_A;
                end
            end
            S_ZERO:  w_state_nxt = S_IDLE;
            S_LD_A:  w_state_nxt = S_LD_B;
            S_LD_B:  w_state_nxt = S_WAIT;
            S_WAIT:  if (w_pop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mul_bus = '0;
        if (r_state == S_LD_A)      w_mul_bus = w_head_a;
        else if (r_state == S_LD_B) w_mul_bus = w_head_b;
    end

    // Control, FIFO pointers, wait counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_wait_cnt    <= 16'd0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (r_state == S_LD_B)      r_wait_cnt <= 16'd0;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 16'd1;

            if (r_state == S_ZERO) begin
                r_out_valid   <= 1'b1;
                r_out_product <= '0;
                r_out_err     <= 1'b0;
            end else if (w_done_ok) begin
                r_out_valid   <= 1'b1;
                r_out_product <= sif.mul_product;
                r_out_err     <= 1'b0;
            end else if (w_timeout) begin
                r_out_valid   <= 1'b1;
                r_out_product <= '0;
                r_out_err     <= 1'b1;
            end else if (r_out_valid && sif.out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    // FIFO payload storage carries no reset; occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr] <= sif.in_a;
            r_fifo_b[r_wr_ptr] <= sif.in_b;
        end
    end

    assign sif.in_ready    = (r_count < 2'd2);
    assign sif.mul_start   = (r_state == S_LD_A);
    assign sif.mul_bus     = w_mul_bus;
    assign sif.out_valid   = r_out_valid;
    assign sif.out_product = r_out_product;
    assign sif.out_err     = r_out_err;
    assign sif.busy        = (r_state != S_IDLE) || (r_count != 2'd0);
endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench: stimulus queues expected results and multiplier jobs; a monitor and a
// behavioural multiplier check the result stream and the operand bus independently.
module tb_mul_operand_sequencer;
    localparam logic [15:0] TMO = 16'd8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_operand_sequencer_if ifc();

    mul_operand_sequencer #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (ifc)
    );

    typedef struct {
        logic [15:0] p;
        logic        e;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        int          d;
    } job_t;

    res_t sb_q[$];
    job_t mq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   push_cyc = 0;
    int   n_starts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (ifc.mul_start) n_starts <= n_starts + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Caller is at posedge+#1; returns at push edge+#1 with in_valid still asserted.
    task automatic push(input logic [15:0] a, input logic [15:0] b, input int d,
                        input logic [15:0] mp, input logic [15:0] ep, input logic ee,
                        input bit expect_res);
        logic rdy;
        int   k;
        res_t r;
        job_t j;
        ifc.in_valid = 1'b1;
        ifc.in_a     = a;
        ifc.in_b     = b;
        rdy = 1'b0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            rdy = ifc.in_ready;
            @(posedge clk);
            if (rdy) break;
        end
        if (k == 400) bound_fail("push_accept");
        #1;
        push_cyc = cyc;
        if (expect_res) begin
            r.p = ep;
            r.e = ee;
            sb_q.push_back(r);
        end
        if (a != 16'd0 && b != 16'd0) begin
            j.a = a;
            j.b = b;
            j.p = mp;
            j.d = d;
            mq.push_back(j);
        end
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ifc.out_valid) break;
        end
        if (k == 100) bound_fail(name);
        else          chk(name, cyc - push_cyc, exp_lat);
        @(posedge clk);
        #1;
    endtask

    // Result monitor: compares each accepted result and checks hold while stalled
    initial begin
        logic        pv, pr, pe;
        logic [15:0] pp;
        res_t        r;
        pv = 1'b0; pr = 1'b0; pe = 1'b0; pp = 16'd0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) begin
                    chk("hold_valid",   ifc.out_valid,   1);
                    chk("hold_product", ifc.out_product, pp);
                    chk("hold_err",     ifc.out_err,     pe);
                end
                if (ifc.out_valid && ifc.out_ready) begin
                    if (sb_q.size() == 0) begin
                        bound_fail("unexpected_result");
                    end else begin
                        r = sb_q.pop_front();
                        chk("result_product", ifc.out_product, r.p);
                        chk("result_err",     ifc.out_err,     r.e);
                    end
                end
            end
            pv = ifc.out_valid;
            pr = ifc.out_ready;
            pp = ifc.out_product;
            pe = ifc.out_err;
        end
    end

    // Behavioural multiplier: checks the bus sequence, answers after d WAIT cycles (0 = never)
    initial begin
        job_t j;
        ifc.mul_done    = 1'b0;
        ifc.mul_product = 16'd0;
        forever begin
            @(negedge clk);
            if (ifc.mul_start) begin
                if (mq.size() == 0) begin
                    bound_fail("unexpected_start");
                end else begin
                    j = mq.pop_front();
                    chk("bus_a", ifc.mul_bus, j.a);
                    @(negedge clk);
                    chk("ld_b_start_low", ifc.mul_start, 0);
                    chk("bus_b", ifc.mul_bus, j.b);
                    for (int i = 1; i <= int'(TMO); i++) begin
                        @(posedge clk);
                        if (i == j.d) begin
                            #1;
                            ifc.mul_done    = 1'b1;
                            ifc.mul_product = j.p;
                        end
                        @(negedge clk);
                        chk("wait_bus_start_zero", {ifc.mul_start, ifc.mul_bus}, 0);
                        if (i == j.d) break;
                    end
                    @(posedge clk);
                    #1;
                    ifc.mul_done    = 1'b0;
                    ifc.mul_product = 16'd0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_a      = 16'd0;
        ifc.in_b      = 16'd0;
        ifc.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",    ifc.in_ready,    1);
        chk("rst_out_valid",   ifc.out_valid,   0);
        chk("rst_out_product", ifc.out_product, 0);
        chk("rst_out_err",     ifc.out_err,     0);
        chk("rst_mul_start",   ifc.mul_start,   0);
        chk("rst_mul_bus",     ifc.mul_bus,     0);
        chk("rst_busy",        ifc.busy,        0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 17*5 with done on the 6th WAIT cycle
        push(16'd17, 16'd5, 6, 16'd85, 16'd85, 1'b0, 1'b1);
        ifc.in_valid = 1'b0;
        wait_out("lat_17x5", 9);

        // Zero operand bypasses the multiplier
        push(16'd0, 16'd9, 0, 16'd0, 16'd0, 1'b0, 1'b1);
        ifc.in_valid = 1'b0;
        wait_out("lat_zero", 2);

        // No done: timeout after 8 WAIT cycles
        push(16'd7, 16'd3, 0, 16'd0, 16'd0, 1'b1, 1'b1);
        ifc.in_valid = 1'b0;
        wait_out("lat_timeout", 11);

        // Done on the timeout cycle wins
        push(16'd7, 16'd3, 8, 16'd21, 16'd21, 1'b0, 1'b1);
        ifc.in_valid = 1'b0;
        wait_out("lat_done_at_timeout", 11);

        // 300*300 = 0x15F90 truncated to 16 bits
        push(16'd300, 16'd300, 3, 16'h5F90, 16'h5F90, 1'b0, 1'b1);
        ifc.in_valid = 1'b0;
        wait_out("lat_300x300", 6);

        // Three back-to-back pairs with the consumer stalled
        ifc.out_ready = 1'b0;
        push(16'd2, 16'd3, 2, 16'd6,  16'd6,  1'b0, 1'b1);
        push(16'd4, 16'd5, 2, 16'd20, 16'd20, 1'b0, 1'b1);
        chk("in_ready_full", ifc.in_ready, 0);
        push(16'd0, 16'd7, 0, 16'd0,  16'd0,  1'b0, 1'b1);
        ifc.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (ifc.out_valid) break;
            end
            if (k == 100) bound_fail("stalled_result_wait");
            @(posedge clk); #1 ifc.out_ready = 1'b1;
            @(posedge clk); #1 ifc.out_ready = 1'b0;
        end
        ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted mid-WAIT discards the job
        push(16'd9, 16'd9, 0, 16'd0, 16'd0, 1'b0, 1'b0);
        ifc.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_busy", ifc.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",      ifc.busy,      0);
        chk("midrst_in_ready",  ifc.in_ready,  1);
        chk("midrst_mul_start", ifc.mul_start, 0);
        chk("midrst_mul_bus",   ifc.mul_bus,   0);
        chk("midrst_out_valid", ifc.out_valid, 0);
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        push(16'd3, 16'd4, 2, 16'd12, 16'd12, 1'b0, 1'b1);
        ifc.in_valid = 1'b0;
        wait_out("lat_after_reset", 5);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("mul_jobs_drained",   mq.size(),   0);
        chk("mul_start_pulses",   n_starts,    8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
